// File: rtl/pll_lock_supervisor_if.sv
// Status/control bundle between the PLL lock supervisor and its environment.
// master = supervisor side, slave = PLL wrapper / status register side.
interface pll_lock_supervisor_if #(
    parameter int CNT_W = 16
);
    logic             pll_locked;
    logic             relock_req;
    logic             pll_rst;
    logic             pll_ready;
    logic [1:0]       state;
    logic [CNT_W-1:0] lock_loss_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    modport master (
        input  pll_locked, relock_req,
        output pll_rst, pll_ready, state, lock_loss_cnt, timeout_cnt
    );

    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, pll_ready, state, lock_loss_cnt, timeout_cnt
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Holds the PLL in reset, qualifies its lock as stable, re-resets it on loss or
// timeout, and keeps saturating loss/timeout event counters.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int SYNC_STAGES         = 2,
    parameter int CNT_W               = 16
) (
    input logic                   refclk,
    input logic                   rst,
    pll_lock_supervisor_if.master bus
);
    typedef enum logic [1:0] {
        RESET_PLL  = 2'd0,
        WAIT_LOCK  = 2'd1,
        STABLE_CHK = 2'd2,
        LOCKED     = 2'd3
    } state_t;

    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(LOCK_STABLE_CYCLES - 1);

    state_t                 state_q, state_next;
    logic [TMR_W-1:0]       tmr;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   timeout_evt, loss_evt;
    logic [CNT_W-1:0]       loss_q, timeout_q;

    // pll_locked is asynchronous to refclk; only the last stage is ever used.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            tmr       <= '0;
            loss_q    <= '0;
            timeout_q <= '0;
        end else begin
            // NOTE: non-blocking here so every flop samples pre-edge values regardless of statement order.
            state_q <= state_next;
            tmr     <= (bus.relock_req || (state_next != state_q)) ? '0 : tmr + 1'b1;
            if (timeout_evt && (timeout_q != '1)) timeout_q <= timeout_q + 1'b1;
            if (loss_evt && (loss_q != '1))       loss_q    <= loss_q + 1'b1;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
        state_next  = state_q;
        timeout_evt = 1'b0;
        loss_evt    = 1'b0;
        if (bus.relock_req) begin
            state_next = RESET_PLL;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (tmr == RST_LAST) state_next = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    // A lock seen on the timeout cycle wins over the timeout.
                    if (locked_s) begin
                        state_next = STABLE_CHK;
                    end else if (tmr == TIMEOUT_LAST) begin
                        state_next  = RESET_PLL;
                        timeout_evt = 1'b1;
                    end
                end
                STABLE_CHK: begin
                    if (!locked_s)                state_next = WAIT_LOCK;
                    else if (tmr == STABLE_LAST) state_next = LOCKED;
                end
                LOCKED: begin
                    if (!locked_s) begin
                        state_next = RESET_PLL;
                        loss_evt   = 1'b1;
                    end
                end
                default: state_next = RESET_PLL;
            endcase
        end
    end

    // Outputs depend on registered state only, so they cannot glitch on input changes.
    always_comb begin
        bus.pll_rst   = (state_q == RESET_PLL);
        bus.pll_ready = (state_q == LOCKED);
        bus.state     = state_q;
    end

    assign bus.lock_loss_cnt = loss_q;
    assign bus.timeout_cnt   = timeout_q;
endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Free-running supervisor in the refclk domain, directly upstream of the fabric PLL wrapper (425 MHz in, 212.5 MHz out).
- Drives the PLL's rst input and consumes its asynchronous locked output.
- Holds the PLL in reset for a fixed time, qualifies lock as stable, and re-resets the PLL on lock loss or lock timeout.
- Publishes a clean pll_ready qualifier plus saturating event counters for status registers.

Parameters:
- PLL_RST_CYCLES, 16: refclk cycles pll_rst is held per reset pulse (>=1).
- LOCK_TIMEOUT_CYCLES, 65536: max refclk cycles in WAIT_LOCK before the PLL is re-reset (>=2).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before pll_ready (>=1).
- SYNC_STAGES, 2: flops in the locked synchronizer (>=2).
- CNT_W, 16: width of the event counters.

Ports:
- refclk, in, 1: reference clock; the only clock.
- rst, in, 1: asynchronous, active-high reset.
- pll_locked, in, 1: PLL locked output; asynchronous to refclk.
- relock_req, in, 1: single-cycle software request to re-reset the PLL.
- pll_rst, out, 1: reset to the PLL.
- pll_ready, out, 1: PLL lock qualified as stable.
- state, out, 2: 0=RESET_PLL, 1=WAIT_LOCK, 2=STABLE_CHK, 3=LOCKED.
- lock_loss_cnt, out, CNT_W: count of LOCKED-to-loss events; saturating.
- timeout_cnt, out, CNT_W: count of WAIT_LOCK timeouts; saturating.

Behaviour:
- Clocking and reset:
  - One clock, refclk. Reset rst is asynchronous and active-high.
  - While rst=1: state=RESET_PLL, pll_rst=1, pll_ready=0, all counters=0, synchronizer flops=0.
- Outputs are decoded from the state register only (glitch-free, no combinational path from inputs):
  - pll_rst = (state==RESET_PLL).
  - pll_ready = (state==LOCKED).
- Synchronizer: locked_s is pll_locked through SYNC_STAGES flops. All decisions use locked_s only.
- One shared timer, tmr. It clears on every state entry.
- RESET_PLL:
  - tmr increments each cycle.
  - When tmr==PLL_RST_CYCLES-1, go to WAIT_LOCK. pll_rst is therefore high for exactly PLL_RST_CYCLES cycles after rst is released.
- WAIT_LOCK:
  - If locked_s=1, go to STABLE_CHK next cycle.
  - Otherwise, when tmr==LOCK_TIMEOUT_CYCLES-1, go to RESET_PLL and increment timeout_cnt.
- STABLE_CHK:
  - If locked_s=0, return to WAIT_LOCK; tmr restarts. No counter increments.
  - When tmr==LOCK_STABLE_CYCLES-1 with locked_s=1, go to LOCKED.
  - pll_ready therefore rises LOCK_STABLE_CYCLES cycles after STABLE_CHK entry.
- LOCKED:
  - If locked_s=0, go to RESET_PLL and increment lock_loss_cnt.
  - pll_ready falls in the same cycle pll_rst rises.
- relock_req:
  - From any state, including RESET_PLL, the next state is RESET_PLL with tmr=0. In RESET_PLL this restarts the reset pulse.
  - No counter increments.
  - relock_req has priority over every other transition in the same cycle.
- Counters:
  - Saturate at all-ones; they never wrap.
  - They are cleared only by rst.
- A timeout coinciding with locked_s rising in WAIT_LOCK resolves to STABLE_CHK; the lock wins.
- Glitch handling: a pll_locked glitch shorter than one refclk cycle may be missed. Any glitch seen on locked_s in STABLE_CHK or LOCKED takes the transition above.
- rst asserted mid-operation: immediate return to reset values, independent of the clock.

Test Plan:
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=64, LOCK_STABLE_CYCLES=8, SYNC_STAGES=2.
1. Power-up lock: release rst with pll_locked=1 held.
   - pll_rst is high for 4 cycles.
   - state goes 1, then 2 after the synchronizer delay.
   - pll_ready rises 8 cycles after STABLE_CHK entry; both counters stay 0.
2. Timeout: pll_locked=0 throughout.
   - pll_rst re-pulses 4 cycles every 68 cycles.
   - timeout_cnt increments once per pulse (3 after three timeouts); pll_ready stays 0.
3. Lock loss: reach LOCKED, then drop pll_locked for 5 cycles.
   - 2 cycles after the drop, pll_ready=0 and pll_rst=1 in the same cycle.
   - lock_loss_cnt=1.
   - After pll_locked returns, the full re-qualification sequence repeats.
4. Unstable lock: in STABLE_CHK, drop pll_locked for 2 cycles at stable count 5.
   - Returns to WAIT_LOCK; pll_rst is not asserted; counters are unchanged.
   - The stable count restarts from 0.
5. relock_req:
   - Pulse in LOCKED: pll_rst for 4 cycles, no counter change.
   - Pulse at RESET_PLL tmr=2: the pulse extends to 7 total cycles.
   - Pulse coinciding with a timeout: RESET_PLL is entered and timeout_cnt is unchanged.
6. Saturation/reset: with CNT_W=2, force 5 timeouts, then assert rst mid-STABLE_CHK.
   - timeout_cnt holds at 3.
   - On rst: all outputs are at reset values asynchronously (pll_rst=1, counters=0).
